// File: rtl/ex_div_pkg.sv
// Shared constants and FSM state type for the EX-stage RV32M divider.
package ex_div_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  localparam logic [6:0] INST_M_FUNCT7 = 7'b0000001;

  localparam logic [DATA_W-1:0] ZERO_WORD     = '0;
  localparam logic [4:0]        ZERO_REG_ADDR = '0;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_START = 2'd1,
    DIV_CALC  = 2'd2,
    DIV_END   = 2'd3
  } div_state_e;

endpackage

// File: rtl/ex_div_if.sv
// EX <-> divider bundle. start_i is a single-cycle request honoured only while busy_o=0;
// ready_o is a one-cycle pulse that qualifies result_o and reg_wr_addr_o.
interface ex_div_if;
  import ex_div_pkg::*;

  logic              start_i;
  logic [2:0]        op_i;
  logic [DATA_W-1:0] dividend_i;
  logic [DATA_W-1:0] divisor_i;
  logic [4:0]        reg_wr_addr_i;
  logic              flush_i;
  logic              busy_o;
  logic              ready_o;
  logic [DATA_W-1:0] result_o;
  logic [4:0]        reg_wr_addr_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, reg_wr_addr_i, flush_i,
    input  busy_o, ready_o, result_o, reg_wr_addr_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, reg_wr_addr_i, flush_i,
    output busy_o, ready_o, result_o, reg_wr_addr_o
  );

endinterface

// File: rtl/ex_div.sv
// Iterative restoring radix-2 divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Operands are held as magnitudes during CALC; the sign is restored on the final step.
module ex_div
  import ex_div_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  ex_div_if.slave    bus,
  output div_state_e state_o
);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic [4:0]        rd_q, rd_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic              signed_op;
  logic              is_rem;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;

  assign signed_op = ~op_q[0];
  assign is_rem    = op_q[1];
  assign shifted   = {rem_q, dvd_q[DATA_W-1]};
  assign diff      = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    rd_d     = rd_q;
    ready_d  = 1'b0;
    result_d = ZERO_WORD;

    if (bus.flush_i) begin
      state_d = DIV_IDLE;
      rd_d    = ZERO_REG_ADDR;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          rd_d = ZERO_REG_ADDR;
          if (bus.start_i) begin
            op_d    = bus.op_i[1:0];
            dvd_d   = bus.dividend_i;
            dvs_d   = bus.divisor_i;
            rd_d    = bus.reg_wr_addr_i;
            state_d = DIV_START;
          end
        end
        DIV_START: begin
          if (dvs_q == ZERO_WORD) begin
            state_d  = DIV_END;
            ready_d  = 1'b1;
            result_d = is_rem ? dvd_q : '1;
          end else begin
            if (signed_op && dvd_q[DATA_W-1]) dvd_d = -dvd_q;
            if (signed_op && dvs_q[DATA_W-1]) dvs_d = -dvs_q;
            q_neg_d = signed_op & (dvd_q[DATA_W-1] ^ dvs_q[DATA_W-1]);
            r_neg_d = signed_op & dvd_q[DATA_W-1];
            cnt_d   = '0;
            quo_d   = ZERO_WORD;
            rem_d   = ZERO_WORD;
            state_d = DIV_CALC;
          end
        end
        DIV_CALC: begin
          // A clear borrow bit means the trial subtraction fits: keep it and emit a 1.
          rem_d = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
          dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d  = DIV_END;
            ready_d  = 1'b1;
            result_d = is_rem ? (r_neg_q ? -rem_d : rem_d)
                              : (q_neg_q ? -quo_d : quo_d);
          end
        end
        DIV_END: begin
          state_d = DIV_IDLE;
          rd_d    = ZERO_REG_ADDR;
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      dvd_q    <= ZERO_WORD;
      dvs_q    <= ZERO_WORD;
      quo_q    <= ZERO_WORD;
      rem_q    <= ZERO_WORD;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      rd_q     <= ZERO_REG_ADDR;
      ready_q  <= 1'b0;
      result_q <= ZERO_WORD;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      rd_q     <= rd_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign bus.busy_o        = (state_q != DIV_IDLE);
  assign bus.ready_o       = ready_q;
  assign bus.result_o      = result_q;
  assign bus.reg_wr_addr_o = rd_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: cycle-level reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_ex_div;
  import ex_div_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op_r;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [4:0]  rd_r;
  logic        flush;
  div_state_e  state_dbg;

  int n_vec;
  int n_fail;

  ex_div_if bus ();

  assign bus.start_i       = start;
  assign bus.op_i          = op_r;
  assign bus.dividend_i    = dvd;
  assign bus.divisor_i     = dvs;
  assign bus.reg_wr_addr_i = rd_r;
  assign bus.flush_i       = flush;

  ex_div dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      INST_DIV:  return 32'(sa / sb);
      INST_DIVU: return 32'(ua / ub);
      INST_REM:  return 32'(sa % sb);
      default:   return 32'(ua % ub);
    endcase
  endfunction

  // ---------------- cycle model + scoreboard ----------------
  logic [31:0] exp_q[$];
  int          m_edge;
  int          m_e0;
  int          m_lat;
  logic        m_act;
  logic [4:0]  m_rd;
  logic        m_on;
  logic        busy_exp;
  logic        ready_exp;

  initial begin
    m_edge = 0; m_e0 = 0; m_lat = 0; m_act = 1'b0; m_rd = '0; m_on = 1'b0;
    busy_exp = 1'b0; ready_exp = 1'b0;
  end

  always @(posedge clk) begin
    bit idle_before;
    m_edge++;
    idle_before = !(m_act && (m_edge - m_e0) <= m_lat);
    if (!rst_n || flush) begin
      m_act = 1'b0;
      exp_q.delete();
    end else if (idle_before) begin
      if (start) begin
        m_act = 1'b1;
        m_e0  = m_edge;
        m_lat = (dvs == 32'h0) ? 2 : 34;
        m_rd  = rd_r;
        exp_q.delete();
        exp_q.push_back(ref_div(op_r, dvd, dvs));
      end else begin
        m_act = 1'b0;
      end
    end
    busy_exp  = m_act && (m_edge - m_e0) <= m_lat - 1;
    ready_exp = m_act && (m_edge - m_e0) == m_lat - 1;
    m_on      = 1'b1;
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("cyc_busy",  32'(bus.busy_o),  32'(busy_exp));
      chk("cyc_ready", 32'(bus.ready_o), 32'(ready_exp));
      chk("cyc_result", bus.result_o, ready_exp ? exp_q[0] : 32'h0);
      chk("cyc_rd", 32'(bus.reg_wr_addr_o), busy_exp ? 32'(m_rd) : 32'h0);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; start is sampled on the following posedge (edge T).
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] lit, input int lit_lat,
                       input bit glitch);
    int n;
    bit seen;
    start = 1'b1; op_r = op; dvd = a; dvs = b; rd_r = rd;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    seen = 1'b0;
    while (!seen && n <= 40) begin
      if (bus.ready_o) seen = 1'b1;
      else begin
        if (glitch && n == 5) begin
          start = 1'b1; op_r = INST_DIVU; dvd = 32'd9; dvs = 32'd2; rd_r = 5'd3;
        end
        if (glitch && n == 6) start = 1'b0;
        @(negedge clk);
        n++;
      end
    end
    chk("ready_seen", 32'(seen), 32'd1);
    chk("latency", 32'(n), 32'(lit_lat));
    chk("result", bus.result_o, lit);
    chk("rd_at_end", 32'(bus.reg_wr_addr_o), 32'(rd));
    @(negedge clk);
    chk("ready_drop", 32'(bus.ready_o), 32'd0);
    chk("rd_idle", 32'(bus.reg_wr_addr_o), 32'd0);
    chk("busy_idle", 32'(bus.busy_o), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  n;
    bit  seen;
    n_vec = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; op_r = INST_DIVU; dvd = '0; dvs = '0; rd_r = '0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(bus.busy_o), 32'd0);
    chk("rst_ready",  32'(bus.ready_o), 32'd0);
    chk("rst_result", bus.result_o, 32'h0);
    chk("rst_rd",     32'(bus.reg_wr_addr_o), 32'd0);
    chk("rst_state",  32'(state_dbg), 32'(DIV_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    do_op(INST_DIVU, 32'd100,        32'd7,          5'd7,  32'd14,         34, 1'b0);
    do_op(INST_REMU, 32'd100,        32'd7,          5'd1,  32'd2,          34, 1'b0);
    do_op(INST_DIV,  32'hFFFFFF9C,   32'd7,          5'd2,  32'hFFFFFFF2,   34, 1'b0);
    do_op(INST_REM,  32'hFFFFFF9C,   32'd7,          5'd3,  32'hFFFFFFFE,   34, 1'b0);
    do_op(INST_REM,  32'd100,        32'hFFFFFFF9,   5'd4,  32'd2,          34, 1'b0);
    do_op(INST_DIVU, 32'd5,          32'd0,          5'd5,  32'hFFFFFFFF,   2,  1'b0);
    do_op(INST_REM,  32'h80000000,   32'd0,          5'd6,  32'h80000000,   2,  1'b0);
    do_op(INST_DIV,  32'h80000000,   32'hFFFFFFFF,   5'd8,  32'h80000000,   34, 1'b0);
    do_op(INST_REM,  32'h80000000,   32'hFFFFFFFF,   5'd9,  32'h0,          34, 1'b0);
    do_op(INST_DIV,  32'd7,          32'hFFFFFFFE,   5'd10, 32'hFFFFFFFD,   34, 1'b0);
    do_op(INST_REM,  32'd7,          32'hFFFFFFFE,   5'd11, 32'd1,          34, 1'b0);
    do_op(INST_DIVU, 32'hFFFFFFFF,   32'h10,         5'd12, 32'h0FFFFFFF,   34, 1'b0);
    do_op(INST_REMU, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd13, 32'h0,          34, 1'b0);
    do_op(INST_DIV,  32'd0,          32'd0,          5'd14, 32'hFFFFFFFF,   2,  1'b0);
    do_op(INST_DIVU, 32'd1000,       32'd3,          5'd15, 32'd333,        34, 1'b1);

    // flush mid-operation, then an immediate restart
    start = 1'b1; op_r = INST_DIVU; dvd = 32'd100; dvs = 32'd7; rd_r = 5'd4;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 10) begin @(negedge clk); n++; end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_state", 32'(state_dbg), 32'(DIV_IDLE));
    chk("flush_busy",  32'(bus.busy_o), 32'd0);
    chk("flush_ready", 32'(bus.ready_o), 32'd0);
    do_op(INST_DIVU, 32'd200, 32'd7, 5'd5, 32'd28, 34, 1'b0);

    // flush coinciding with start in IDLE
    start = 1'b1; flush = 1'b1; op_r = INST_DIV; dvd = 32'd9; dvs = 32'd3; rd_r = 5'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", 32'(bus.busy_o), 32'd0);
    chk("flush_start_rd",   32'(bus.reg_wr_addr_o), 32'd0);
    @(negedge clk);

    // reset mid-operation
    start = 1'b1; op_r = INST_DIVU; dvd = 32'd100; dvs = 32'd7; rd_r = 5'd7;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 20) begin
      chk("rd_held", 32'(bus.reg_wr_addr_o), 32'd7);
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_busy",   32'(bus.busy_o), 32'd0);
    chk("mrst_ready",  32'(bus.ready_o), 32'd0);
    chk("mrst_result", bus.result_o, 32'h0);
    chk("mrst_rd",     32'(bus.reg_wr_addr_o), 32'd0);
    chk("mrst_state",  32'(state_dbg), 32'(DIV_IDLE));
    seen = 1'b0;
    repeat (20) begin
      if (bus.ready_o) seen = 1'b1;
      @(negedge clk);
    end
    chk("mrst_no_ready", 32'(seen), 32'd0);

    do_op(INST_REMU, 32'd12345, 32'd100, 5'd31, 32'd45, 34, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
